// File: rtl/seg_rx_pkg.sv
// seg_rx_pkg
//   Shared definitions for the 7-segment capture receiver: segment bus width,
//   capture FSM state type, anode strobe codes, the hex glyph table and the
//   pattern -> {bad, hex} lookup used by the glyph decoder.
//   Build option: SEG_RX_DP_EN widens the segment bus to 8 bits (bit7 = dp).
package seg_rx_pkg;

`ifdef SEG_RX_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif

  typedef enum logic [2:0] {
    WAIT0   = 3'd0,
    SETTLE0 = 3'd1,
    WAIT1   = 3'd2,
    SETTLE1 = 3'd3,
    PRESENT = 3'd4
  } rx_state_t;

  // Synchronized anode codes (active-low strobes)
  localparam logic [1:0] AN_DIGIT0 = 2'b10;
  localparam logic [1:0] AN_DIGIT1 = 2'b01;

  // Active-high {g..a} glyphs, entry i is the glyph for hex value i
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Returns {bad, hex}; unknown patterns give value 0 with bad set
  function automatic logic [4:0] glyph_lookup(input logic [6:0] pattern);
    logic [4:0] result;
    result = 5'b1_0000;
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPH_TABLE[i]) begin
        result = {1'b0, 4'(i)};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// seg_glyph_decode
//   Combinational decode of one active-high 7-segment pattern into a hex digit.
//   Ports:
//     pattern  in  7  active-high segments, bit0=a .. bit6=g
//     hex      out 4  decoded value (0 when no glyph matches)
//     bad      out 1  pattern matched no hex glyph
module seg_glyph_decode
  import seg_rx_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] hex,
  output logic       bad
);

  assign {bad, hex} = glyph_lookup(pattern);

endmodule

// File: rtl/seg_capture_rx.sv
// seg_capture_rx
//   Samples a time-multiplexed two-digit active-low segment/anode bus and
//   recovers the displayed hex digit pair, offered over valid/ready.
//   A digit is accepted once STABLE_CYCLES consecutive synchronized samples
//   show its anode lit with an unchanged segment pattern.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     seg_in  [SEG_W]     active-low segments (bit7 = dp when SEG_RX_DP_EN)
//     an_in   [2]         active-low anodes: 10 digit0, 01 digit1, else none
//     out_ready           consumer accepts the pair
//     out_valid           pair held on digit0/digit1/bad0/bad1
//     digit0/1, bad0/1    decoded digits and no-glyph flags
//     dp0/dp1             decimal points (only when SEG_RX_DP_EN is defined)
//     overrun             sticky: digit0 strobe started while a pair was pending
//   Build option: SEG_RX_DP_EN adds dp capture and the dp0/dp1 outputs.
module seg_capture_rx
  import seg_rx_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEG_W-1:0] seg_in,
  input  logic [1:0]       an_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic             bad0,
  output logic             bad1,
`ifdef SEG_RX_DP_EN
  output logic             dp0,
  output logic             dp1,
`endif
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SEG_W-1:0] seg_sync1_reg, seg_sync2_reg;
  logic [1:0]       an_sync1_reg, an_sync2_reg, an_last_reg;
  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [SEG_W-1:0] prev_reg, prev_next;
  logic [3:0]       digit0_reg, digit1_reg;
  logic             bad0_reg, bad1_reg, overrun_reg;
  logic             cap0, cap1, overrun_set;
  logic [SEG_W-1:0] seg_now;
  logic [1:0]       an_now;
  logic [3:0]       dec_hex;
  logic             dec_bad;

  // Two-flop synchronizers; reset value is the "all off" pin state
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_sync1_reg <= '1;
      seg_sync2_reg <= '1;
      an_sync1_reg  <= 2'b11;
      an_sync2_reg  <= 2'b11;
      an_last_reg   <= 2'b11;
    end else begin
      seg_sync1_reg <= seg_in;
      seg_sync2_reg <= seg_sync1_reg;
      an_sync1_reg  <= an_in;
      an_sync2_reg  <= an_sync1_reg;
      an_last_reg   <= an_sync2_reg;
    end
  end

  assign seg_now = ~seg_sync2_reg;
  assign an_now  = an_sync2_reg;

  seg_glyph_decode u_decode (
    .pattern (seg_now[6:0]),
    .hex     (dec_hex),
    .bad     (dec_bad)
  );

  // Saturating increment so the counter can never wrap
  assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_ONE;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= WAIT0;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state plus settle-counter / capture controls
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    prev_next  = prev_reg;
    cap0       = 1'b0;
    cap1       = 1'b0;
    case (state_reg)
      WAIT0: begin
        if (an_now == AN_DIGIT0) begin
          state_next = SETTLE0;
          cnt_next   = CNT_ONE;
          prev_next  = seg_now;
        end
      end
      SETTLE0: begin
        if (an_now != AN_DIGIT0) begin
          state_next = WAIT0;
        end else if (seg_now == prev_reg) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_DONE) begin
            cap0       = 1'b1;
            state_next = WAIT1;
          end
        end else begin
          cnt_next  = CNT_ONE;
          prev_next = seg_now;
        end
      end
      WAIT1: begin
        // A digit0 strobe seen here is ignored; digit0 stays captured
        if (an_now == AN_DIGIT1) begin
          state_next = SETTLE1;
          cnt_next   = CNT_ONE;
          prev_next  = seg_now;
        end
      end
      SETTLE1: begin
        if (an_now != AN_DIGIT1) begin
          state_next = WAIT1;
        end else if (seg_now == prev_reg) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_DONE) begin
            cap1       = 1'b1;
            state_next = PRESENT;
          end
        end else begin
          cnt_next  = CNT_ONE;
          prev_next = seg_now;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_next = WAIT0;
        end
      end
      default: state_next = WAIT0;
    endcase
  end

  // FSM: outputs
  always_comb begin
    out_valid = (state_reg == PRESENT);
  end

  // Overrun: a fresh digit0 strobe while the pair is still unclaimed
  assign overrun_set = (state_reg == PRESENT) && (an_now == AN_DIGIT0) &&
                       (an_last_reg != AN_DIGIT0) && !out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      prev_reg    <= '1;
      digit0_reg  <= 4'h0;
      digit1_reg  <= 4'h0;
      bad0_reg    <= 1'b0;
      bad1_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      prev_reg <= prev_next;
      if (cap0) begin
        digit0_reg <= dec_hex;
        bad0_reg   <= dec_bad;
      end
      if (cap1) begin
        digit1_reg <= dec_hex;
        bad1_reg   <= dec_bad;
      end
      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign digit0  = digit0_reg;
  assign digit1  = digit1_reg;
  assign bad0    = bad0_reg;
  assign bad1    = bad1_reg;
  assign overrun = overrun_reg;

`ifdef SEG_RX_DP_EN
  logic dp0_reg, dp1_reg;

  // dp is captured alongside its digit; it already takes part in the
  // stability compare because prev_reg holds the full bus
  always_ff @(posedge clk) begin
    if (reset) begin
      dp0_reg <= 1'b0;
      dp1_reg <= 1'b0;
    end else begin
      if (cap0) begin
        dp0_reg <= seg_now[7];
      end
      if (cap1) begin
        dp1_reg <= seg_now[7];
      end
    end
  end

  assign dp0 = dp0_reg;
  assign dp1 = dp1_reg;
`endif

endmodule

// File: tb/tb_seg_capture_rx.sv
// tb_seg_capture_rx
//   Directed scenarios plus randomized digit streams for seg_capture_rx,
//   checked every cycle against a run-length reference model.
module tb_seg_capture_rx;
  import seg_rx_pkg::SEG_W;

  localparam int STABLE = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [SEG_W-1:0] seg_in = '1;
  logic [1:0]       an_in = 2'b11;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [3:0]       digit0, digit1;
  logic             bad0, bad1, overrun;
`ifdef SEG_RX_DP_EN
  logic             dp0, dp1;
`endif

  seg_capture_rx #(.STABLE_CYCLES(STABLE), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .an_in     (an_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .digit0    (digit0),
    .digit1    (digit1),
    .bad0      (bad0),
    .bad1      (bad1),
`ifdef SEG_RX_DP_EN
    .dp0       (dp0),
    .dp1       (dp1),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_pairs  = 0;
  int ready_mode = 0;  // 0 low, 1 high, 2 random

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Active-high glyph for each hex value
  function automatic logic [6:0] seg_of_hex(input int h);
    case (h)
      0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;   3: return 7'h4F;
      4: return 7'h66;   5: return 7'h6D;   6: return 7'h7D;   7: return 7'h07;
      8: return 7'h7F;   9: return 7'h6F;   10: return 7'h77;  11: return 7'h7C;
      12: return 7'h39;  13: return 7'h5E;  14: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [4:0] ref_decode(input logic [6:0] hi);
    for (int h = 0; h < 16; h++) begin
      if (seg_of_hex(h) == hi) return {1'b0, 4'(h)};
    end
    return 5'b1_0000;
  endfunction

  function automatic logic [SEG_W-1:0] pins_of(input logic [6:0] hi);
    logic [SEG_W-1:0] v;
    v = '1;
    v[6:0] = ~hi;
    return v;
  endfunction

  // Reference model: pins reach the capture logic two edges late; a digit is
  // taken when STABLE consecutive delayed samples show its anode with one
  // unchanged pattern, counted from when that digit became the one sought.
  logic [SEG_W-1:0] h1_seg = '1, h2_seg = '1, run_pat = '1;
  logic [1:0]       h1_an = 2'b11, h2_an = 2'b11, h3_an = 2'b11;
  int               m_phase = 0, run_len = 0;
  logic [3:0]       m_d0 = 0, m_d1 = 0;
  logic             m_b0 = 0, m_b1 = 0, m_ovr = 0, m_dp0 = 0, m_dp1 = 0;

  task automatic model_edge();
    logic [1:0] tgt;
    logic [4:0] dec;
    if (reset) begin
      h1_seg = '1; h2_seg = '1; h1_an = 2'b11; h2_an = 2'b11; h3_an = 2'b11;
      m_phase = 0; run_len = 0;
      m_d0 = 0; m_d1 = 0; m_b0 = 0; m_b1 = 0; m_ovr = 0; m_dp0 = 0; m_dp1 = 0;
      return;
    end
    if (m_phase == 2) begin
      if (h2_an == 2'b10 && h3_an != 2'b10 && !out_ready) m_ovr = 1'b1;
      if (out_ready) begin
        n_pairs++;
        $display("pair %0d: digit0=%h bad0=%0b digit1=%h bad1=%0b overrun=%0b",
                 n_pairs, m_d0, m_b0, m_d1, m_b1, m_ovr);
        m_phase = 0;
        run_len = 0;
      end
    end else begin
      tgt = (m_phase == 0) ? 2'b10 : 2'b01;
      if (h2_an == tgt) begin
        if (run_len > 0 && h2_seg == run_pat) run_len++;
        else begin
          run_len = 1;
          run_pat = h2_seg;
        end
        if (run_len == STABLE) begin
          dec = ref_decode(~h2_seg[6:0]);
          if (m_phase == 0) begin
            {m_b0, m_d0} = dec;
            m_dp0 = ~h2_seg[SEG_W-1] && (SEG_W == 8);
          end else begin
            {m_b1, m_d1} = dec;
            m_dp1 = ~h2_seg[SEG_W-1] && (SEG_W == 8);
          end
          m_phase++;
          run_len = 0;
        end
      end else begin
        run_len = 0;
      end
    end
    h3_an  = h2_an;
    h2_an  = h1_an;
    h2_seg = h1_seg;
    h1_an  = an_in;
    h1_seg = seg_in;
  endtask

  task automatic tick();
    if (ready_mode == 2) out_ready = ($urandom_range(0, 2) == 0);
    else out_ready = (ready_mode == 1);
    @(posedge clk);
    model_edge();
    #1;
    check("out_valid", 32'(out_valid), 32'(m_phase == 2));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("digits", {22'd0, digit1, digit0, bad1, bad0}, {22'd0, m_d1, m_d0, m_b1, m_b0});
`ifdef SEG_RX_DP_EN
    check("dp", {30'd0, dp1, dp0}, {30'd0, m_dp1, m_dp0});
`endif
  endtask

  task automatic hold(input logic [1:0] an_v, input logic [SEG_W-1:0] pins, input int n);
    for (int i = 0; i < n; i++) begin
      an_in  = an_v;
      seg_in = pins;
      tick();
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_digits", {24'd0, digit1, digit0}, 32'd0);
    check("rst_flags", {29'd0, bad1, bad0, overrun}, 32'd0);
  endtask

  task automatic rand_digit(input logic [1:0] an_v);
    logic [6:0] hi;
    int n;
    if ($urandom_range(0, 7) == 0) hi = 7'($urandom);
    else hi = seg_of_hex($urandom_range(0, 15));
    n = $urandom_range(8, 28);
    for (int i = 0; i < n; i++) begin
      an_in  = an_v;
      seg_in = pins_of(hi);
      if ($urandom_range(0, 19) == 0) seg_in = pins_of(hi ^ 7'h01);
      tick();
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    hold(2'b11, '1, 3);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;

    // 1: digits 0 and 1
    ready_mode = 0;
    hold(2'b10, pins_of(7'h3F), 20);
    hold(2'b01, pins_of(7'h06), 20);
    hold(2'b11, '1, 3);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_digits", {24'd0, digit1, digit0}, 32'h10);
    check("t1_bad", {30'd0, bad1, bad0}, 32'd0);
    ready_mode = 1;
    hold(2'b11, '1, 2);

    // 2: A/F held under backpressure, then overrun, then handshake
    ready_mode = 0;
    hold(2'b10, pins_of(7'h77), 20);
    hold(2'b01, pins_of(7'h71), 20);
    hold(2'b11, '1, 50);
    check("t2_digits", {24'd0, digit1, digit0}, 32'hFA);
    check("t2_no_overrun", 32'(overrun), 32'd0);
    hold(2'b10, pins_of(7'h3F), 5);
    check("t2_overrun", 32'(overrun), 32'd1);
    check("t2_still_valid", 32'(out_valid), 32'd1);
    ready_mode = 1;
    hold(2'b10, pins_of(7'h3F), 1);
    check("t2_valid_drop", 32'(out_valid), 32'd0);
    hold(2'b11, '1, 3);

    // 3: digit0 toggling 3 vs 8 never settles, then steady 3
    ready_mode = 0;
    for (int k = 0; k < 6; k++) hold(2'b10, pins_of((k % 2) ? 7'h7F : 7'h4F), 10);
    hold(2'b10, pins_of(7'h4F), 20);
    hold(2'b01, pins_of(7'h5B), 20);
    check("t3_digits", {24'd0, digit1, digit0}, 32'h23);
    ready_mode = 1;
    hold(2'b11, '1, 2);

    // 4: unknown digit0 glyph
    ready_mode = 0;
    hold(2'b10, pins_of(7'h49), 20);
    hold(2'b01, pins_of(7'h6F), 20);
    check("t4_bad0", {31'd0, bad0}, 32'd1);
    check("t4_digits", {24'd0, digit1, digit0}, 32'h90);
    ready_mode = 1;
    hold(2'b11, '1, 2);

    // 5: anode drops mid-settle; re-strobe counts from one
    ready_mode = 0;
    hold(2'b10, pins_of(7'h66), 12);
    hold(2'b11, '1, 3);
    hold(2'b10, pins_of(7'h6D), 17);
    check("t5_not_yet", 32'(out_valid), 32'd0);
    hold(2'b10, pins_of(7'h6D), 3);
    hold(2'b01, pins_of(7'h7D), 20);
    check("t5_digits", {24'd0, digit1, digit0}, 32'h65);
    ready_mode = 1;
    hold(2'b11, '1, 2);

    // 6: reset in SETTLE1, then in PRESENT
    ready_mode = 0;
    hold(2'b10, pins_of(7'h07), 20);
    hold(2'b01, pins_of(7'h7C), 8);
    pulse_reset();
    hold(2'b10, pins_of(7'h39), 20);
    hold(2'b01, pins_of(7'h5E), 20);
    check("t6_valid", 32'(out_valid), 32'd1);
    pulse_reset();
    hold(2'b11, '1, 3);

    // Randomized streams with glitches, gaps and random ready
    ready_mode = 2;
    for (int k = 0; k < 40; k++) begin
      rand_digit(2'b10);
      if ($urandom_range(0, 3) == 0) hold($urandom_range(0, 1) ? 2'b11 : 2'b00, '1, $urandom_range(1, 4));
      rand_digit(2'b01);
      if ($urandom_range(0, 3) == 0) hold($urandom_range(0, 1) ? 2'b11 : 2'b00, '1, $urandom_range(1, 4));
    end
    ready_mode = 1;
    hold(2'b11, '1, 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
